// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end that shares one shift-add multiplier
// between two requesters.
//
// Ports
//   clk_10kHz   in   system clock, rising edge
//   clrn        in   synchronous active-low reset
//   req[1:0]    in   per-requester request, held until its gnt bit pulses
//   a0,b0,a1,b1 in   requester operands, sampled at grant
//   gnt[1:0]    out  one-hot grant, 1-cycle pulse
//   rsp_valid   out  1-cycle pulse qualifying rsp_id/rsp_p/rsp_err
//   rsp_id      out  requester owning the response
//   rsp_p       out  product (0 on error)
//   rsp_err     out  multiplier timed out
//   busy        out  high whenever the FSM is not idle
//   state[2:0]  out  FSM state (debug)
//   mul_a/mul_b out  operand buses to the multiplier
//   mul_load_a/mul_load_b/mul_start out  multiplier control pulses
//   mul_p       in   multiplier product
//   mul_done    in   multiplier done level (rising edge used)
module mult_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic               clk_10kHz,
  input  logic               clrn,
  input  logic [1:0]         req,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic [1:0]         gnt,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_p,
  output logic               rsp_err,
  output logic               busy,
  output logic [2:0]         state,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_load_a,
  output logic               mul_load_b,
  output logic               mul_start,
  input  logic [2*WIDTH-1:0] mul_p,
  input  logic               mul_done
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadA = 3'd1,
    StLoadB = 3'd2,
    StStart = 3'd3,
    StWait  = 3'd4,
    StResp  = 3'd5
  } state_e;

  state_e          st;
  logic            cur_id;
  logic            last_id;
  logic            done_q;
  logic [CntW-1:0] cnt;
  logic            pick;
  logic            done_rise;

  assign state     = st;
  assign done_rise = mul_done & ~done_q;

  // With both requests pending, serve whoever was not served last.
  always_comb begin
    pick = req[1];
    if (req == 2'b11) pick = ~last_id;
  end

  always_ff @(posedge clk_10kHz) begin
    if (!clrn) begin
      st         <= StIdle;
      cur_id     <= 1'b0;
      last_id    <= 1'b1;  // so req0 wins the first tie
      done_q     <= 1'b0;
      cnt        <= '0;
      gnt        <= 2'b00;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_p      <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_load_a <= 1'b0;
      mul_load_b <= 1'b0;
      mul_start  <= 1'b0;
    end else begin
      // done_q tracks every cycle so a level already high at WAIT entry is not an edge.
      done_q     <= mul_done;
      gnt        <= 2'b00;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      mul_load_a <= 1'b0;
      mul_load_b <= 1'b0;
      mul_start  <= 1'b0;
      unique case (st)
        StIdle: begin
          if (req != 2'b00) begin
            cur_id     <= pick;
            mul_a      <= pick ? a1 : a0;
            mul_b      <= pick ? b1 : b0;
            gnt        <= pick ? 2'b10 : 2'b01;
            mul_load_a <= 1'b1;
            busy       <= 1'b1;
            st         <= StLoadA;
          end
        end
        StLoadA: begin
          mul_load_b <= 1'b1;
          st         <= StLoadB;
        end
        StLoadB: begin
          mul_start <= 1'b1;
          st        <= StStart;
        end
        StStart: begin
          cnt <= '0;
          st  <= StWait;
        end
        StWait: begin
          if (done_rise) begin
            rsp_p     <= mul_p;
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            st        <= StResp;
          end else if (cnt == CntW'(TIMEOUT)) begin
            rsp_p     <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            st        <= StResp;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StResp: begin
          last_id <= cur_id;
          busy    <= 1'b0;
          st      <= StIdle;
        end
        default: begin
          busy <= 1'b0;
          st   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios plus a randomized run, checked
// against a transaction-level model (arbitration rule, product, latency).
module tb_mult_arbiter;

  localparam int W  = 8;
  localparam int TO = 31;

  logic           clk = 1'b0;
  logic           clrn;
  logic [1:0]     req;
  logic [W-1:0]   a0, b0, a1, b1;
  logic [1:0]     gnt;
  logic           rsp_valid;
  logic           rsp_id;
  logic [2*W-1:0] rsp_p;
  logic           rsp_err;
  logic           busy;
  logic [2:0]     state;
  logic [W-1:0]   mul_a, mul_b;
  logic           mul_load_a, mul_load_b, mul_start;
  logic [2*W-1:0] mul_p;
  logic           mul_done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Multiplier model state
  int since      = -1;
  bit hold_done  = 1'b0;
  bit never_done = 1'b0;
  // Arbitration model: last requester served (1 after reset so req0 wins a tie)
  bit last       = 1'b1;

  mult_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_10kHz (clk),
    .clrn      (clrn),
    .req       (req),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .state     (state),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_load_a(mul_load_a),
    .mul_load_b(mul_load_b),
    .mul_start (mul_start),
    .mul_p     (mul_p),
    .mul_done  (mul_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; then the multiplier model reacts to what it sees this cycle.
  // Done rises WIDTH+1 cycles after the start pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mul_start) begin
      since = 0;
      if (!hold_done) mul_done = 1'b0;
    end else if (since >= 0) begin
      since++;
    end
    if (since == 3) mul_done = 1'b0;
    if (since == W + 1 && !never_done) begin
      mul_p    = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
      mul_done = 1'b1;
    end
  endtask

  // Full transaction starting from an IDLE cycle.
  task automatic run_op(input logic [1:0] r, input bit drop, input bit exp_err);
    int          w;
    int          lat;
    logic [31:0] exp_p;
    w     = (r == 2'b11) ? int'(!last) : int'(r[1]);
    exp_p = exp_err ? 32'd0 : (w == 1 ? int'(a1) * int'(b1) : int'(a0) * int'(b0));
    req   = r;
    lat   = 0;
    do begin
      tick();
      lat++;
    end while (gnt == 2'b00 && lat < 40);
    check("gnt_latency", lat, 1);
    check("gnt_onehot", gnt, (w == 1) ? 2'b10 : 2'b01);
    check("load_a", mul_load_a, 1);
    check("mul_a", mul_a, (w == 1) ? a1 : a0);
    check("mul_b", mul_b, (w == 1) ? b1 : b0);
    if (drop) req[w] = 1'b0;
    tick();
    check("load_b_cycle", {gnt, mul_load_a, mul_load_b, mul_start}, 5'b00010);
    tick();
    check("start_cycle", {gnt, mul_load_a, mul_load_b, mul_start}, 5'b00001);
    check("busy", busy, 1);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!rsp_valid && lat < 60);
    check("rsp_latency", lat, exp_err ? TO + 2 : W + 2);
    check("rsp_id", rsp_id, w);
    check("rsp_p", rsp_p, exp_p);
    check("rsp_err", rsp_err, exp_err);
    tick();
    check("idle_after_resp", {rsp_valid, busy, state}, 5'b00000);
    last = (w == 1);
  endtask

  initial begin
    int n;
    bit seen;
    clrn = 1'b0; req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    mul_p = '0; mul_done = 1'b0;
    tick();
    tick();
    check("reset_ctrl", {gnt, rsp_valid, rsp_id, rsp_err, busy, state,
                         mul_load_a, mul_load_b, mul_start}, 0);
    check("reset_data", {rsp_p, mul_a, mul_b}, 0);
    clrn = 1'b1;
    tick();

    // Tie right after reset: req0 first, then req1
    a0 = 8'd125; b0 = 8'd2; a1 = 8'd255; b1 = 8'd255;
    run_op(2'b11, 1'b1, 1'b0);
    run_op(2'b10, 1'b1, 1'b0);

    // Single requester 0
    a0 = 8'd62; b0 = 8'd3;
    run_op(2'b01, 1'b1, 1'b0);

    // Both held for four operations: alternates
    a0 = 8'd17; b0 = 8'd9; a1 = 8'd200; b1 = 8'd7;
    repeat (4) run_op(2'b11, 1'b0, 1'b0);

    // Done still high from the previous op must not give an early response
    a1 = 8'd0; b1 = 8'd200; hold_done = 1'b1;
    run_op(2'b10, 1'b1, 1'b0);
    hold_done = 1'b0;

    // Multiplier never finishes: timeout
    never_done = 1'b1; a0 = 8'd5; b0 = 8'd6;
    run_op(2'b01, 1'b1, 1'b1);
    never_done = 1'b0;

    // Randomized operations
    for (int i = 0; i < 16; i++) begin
      a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      hold_done = bit'($urandom_range(0, 1));
      run_op(2'($urandom_range(1, 3)), bit'($urandom_range(0, 1)), 1'b0);
    end
    hold_done = 1'b0;

    // Reset during WAIT aborts with no response; afterwards req0 wins a tie
    a0 = 8'd11; b0 = 8'd13;
    req = 2'b01;
    n = 0;
    do begin
      tick();
      n++;
    end while (state != 3'd4 && n < 20);
    check("reached_wait", state, 4);
    req  = 2'b00;
    clrn = 1'b0;
    tick();
    check("abort_ctrl", {gnt, rsp_valid, rsp_id, rsp_err, busy, state,
                         mul_load_a, mul_load_b, mul_start}, 0);
    check("abort_data", {rsp_p, mul_a, mul_b}, 0);
    clrn = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_abort", seen, 0);
    last = 1'b1;
    a0 = 8'd3; b0 = 8'd4; a1 = 8'd7; b1 = 8'd8;
    run_op(2'b11, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
